video_timing_gen: RTL and testbench

//  Video source: parameterised raster timing generator with built-in test patterns.

---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/video_pattern_gen.sv | 32 +++
 rtl/video_timing_gen.sv | 125 ++++++++++++
 tb/tb_video_timing_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and colour constants for the raster timing generator and its pattern source.
package video_timing_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  localparam rgb_t C_WHITE   = 24'hFFFFFF;
  localparam rgb_t C_YELLOW  = 24'hFFFF00;
  localparam rgb_t C_CYAN    = 24'h00FFFF;
  localparam rgb_t C_GREEN   = 24'h00FF00;
  localparam rgb_t C_MAGENTA = 24'hFF00FF;
  localparam rgb_t C_RED     = 24'hFF0000;
  localparam rgb_t C_BLUE    = 24'h0000FF;
  localparam rgb_t C_BLACK   = 24'h000000;

  // Bars run left to right in order of decreasing luminance.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = C_WHITE;
      3'd1:    bar_colour = C_YELLOW;
      3'd2:    bar_colour = C_CYAN;
      3'd3:    bar_colour = C_GREEN;
      3'd4:    bar_colour = C_MAGENTA;
      3'd5:    bar_colour = C_RED;
      3'd6:    bar_colour = C_BLUE;
      default: bar_colour = C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern colour for the current raster position.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int CW_H = 9,
  parameter int CW_V = 9
) (
  input  logic [1:0]      pat,
  input  logic [CW_H-1:0] h_cnt,
  input  logic [CW_V-1:0] v_cnt,
  input  logic [2:0]      bar_idx,
  output logic [23:0]     rgb
);

  rgb_t       colour;
  logic       chk;
  logic [7:0] ramp;

  always_comb begin
    // 8x8 checker cells: bit 3 of each counter selects the cell parity.
    chk  = (|((h_cnt >> 3) & CW_H'(1))) ^ (|((v_cnt >> 3) & CW_V'(1)));
    ramp = 8'(h_cnt);
    case (pattern_e'(pat))
      PAT_BARS:  colour = bar_colour(bar_idx);
      PAT_CHECK: colour = chk ? C_WHITE : C_BLACK;
      PAT_RAMP:  colour = {ramp, ramp, ramp};
      default:   colour = C_BLACK;
    endcase
    rgb = colour;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered sync/DE/pixel outputs and a built-in test pattern.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 320,
  parameter int   H_FP     = 8,
  parameter int   H_SYNC   = 32,
  parameter int   H_BP     = 40,
  parameter int   V_ACTIVE = 240,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 15,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  CW_H     = $clog2(H_TOTAL),
  localparam int  CW_V     = $clog2(V_TOTAL)
) (
  input  logic            clk_vid,
  input  logic            reset_n,
  input  logic            ce_pix,
  input  logic [1:0]      pat_sel,
  output logic [23:0]     vid_rgb,
  output logic            vid_hs,
  output logic            vid_vs,
  output logic            vid_de,
  output logic [CW_H-1:0] pix_x,
  output logic [CW_V-1:0] pix_y,
  output logic            frame_start
);

  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [CW_H-1:0] h_cnt;
  logic [CW_V-1:0] v_cnt;
  logic [CW_H-1:0] bar_cnt;
  logic [2:0]      bar_idx;
  logic [1:0]      pat_q;

  logic            first_px;
  logic            h_last;
  logic            v_last;
  logic            bar_last;
  logic            de_now;
  logic            hs_now;
  logic            vs_now;
  logic [1:0]      pat_cur;
  logic [23:0]     colour;

  always_comb begin
    first_px = (h_cnt == '0) && (v_cnt == '0);
    h_last   = int'(h_cnt) == H_TOTAL - 1;
    v_last   = int'(v_cnt) == V_TOTAL - 1;
    bar_last = int'(bar_cnt) == BAR_W - 1;
    de_now   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    hs_now   = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    vs_now   = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
    // Pixel (0,0) already uses the newly sampled pattern so a frame never mixes two.
    pat_cur  = first_px ? pat_sel : pat_q;
  end

  video_pattern_gen #(
    .CW_H (CW_H),
    .CW_V (CW_V)
  ) u_pattern (
    .pat     (pat_cur),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .bar_idx (bar_idx),
    .rgb     (colour)
  );

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      pat_q       <= '0;
      vid_rgb     <= '0;
      vid_hs      <= ~HS_POL;
      vid_vs      <= ~VS_POL;
      vid_de      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else if (ce_pix) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CW_V'(1);
      end else begin
        h_cnt <= h_cnt + CW_H'(1);
      end

      // Bar index tracks h_cnt by counting BAR_W-pixel runs, avoiding a divider.
      if (h_last) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_last) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + CW_H'(1);
      end

      if (first_px) begin
        pat_q <= pat_sel;
      end

      vid_rgb     <= de_now ? colour : 24'h000000;
      vid_hs      <= hs_now ? HS_POL : ~HS_POL;
      vid_vs      <= vs_now ? VS_POL : ~VS_POL;
      vid_de      <= de_now;
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      frame_start <= first_px;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen against a raster-position reference model (small 24x12 raster).
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 8, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk_vid = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix  = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [23:0] vid_rgb;
  logic        vid_hs, vid_vs, vid_de, frame_start;
  logic [4:0]  pix_x;
  logic [3:0]  pix_y;
  logic [36:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: linear position within the frame plus the expected registered outputs.
  int          m_pos;
  logic [1:0]  m_pat;
  logic [23:0] e_rgb;
  logic        e_hs, e_vs, e_de, e_fs;
  int          e_x, e_y;

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut (
    .clk_vid     (clk_vid),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .pat_sel     (pat_sel),
    .vid_rgb     (vid_rgb),
    .vid_hs      (vid_hs),
    .vid_vs      (vid_vs),
    .vid_de      (vid_de),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start)
  );

  always #5 clk_vid = ~clk_vid;

  assign obs = {vid_rgb, vid_hs, vid_vs, vid_de, pix_x, pix_y, frame_start};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] ref_colour(input int x, input int y, input logic [1:0] pat);
    if (!(x < HA && y < VA)) return 24'h0;
    case (pat)
      2'd1:    return BARS[x / (HA / 8)];
      2'd2:    return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
      2'd3:    return {3{8'(x % 256)}};
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [36:0] exp_vec();
    return {e_rgb, e_hs, e_vs, e_de, 5'(e_x), 4'(e_y), e_fs};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pat = 2'd0;
    e_rgb = 24'h0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0;
    e_x = 0; e_y = 0;
  endtask

  // Drive one clock with the given ce/pattern and advance the model on a ce.
  task automatic cyc(input logic ce, input logic [1:0] ps);
    int x, y;
    ce_pix  = ce;
    pat_sel = ps;
    @(posedge clk_vid);
    if (ce) begin
      x = m_pos % HT;
      y = m_pos / HT;
      if (m_pos == 0) m_pat = ps;
      e_de  = (x < HA) && (y < VA);
      e_hs  = (x >= HA + HF) && (x < HA + HF + HSW);
      e_vs  = (y >= VA + VF) && (y < VA + VF + VSW);
      e_fs  = (m_pos == 0);
      e_x   = x;
      e_y   = y;
      e_rgb = ref_colour(x, y, m_pat);
      m_pos = (m_pos + 1) % FT;
    end
    #1;
  endtask

  task automatic apply_reset(input int n, input logic [1:0] ps);
    reset_n = 1'b0;
    pat_sel = ps;
    model_reset();
    repeat (n) begin
      @(posedge clk_vid);
      #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_vid);
      #1;
      n_assert++;
      if (obs !== 37'h0) begin
        n_fail++;
        $display("FAIL reset_values cyc %0d: got %h want %h", i, obs, 37'h0);
      end
    end
    reset_n = 1'b1;
    cyc(1'b1, 2'd0);
    n_assert++;
    if ({vid_de, frame_start, pix_x, pix_y} !== {1'b1, 1'b1, 5'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL first_pixel: got de=%b fs=%b x=%0d y=%0d want de=1 fs=1 x=0 y=0",
               vid_de, frame_start, pix_x, pix_y);
    end
  endtask

  task automatic test_line_timing();
    int fs_n, de_n, hs_n, vs_n;
    fs_n = 0; de_n = 0; hs_n = 0; vs_n = 0;
    apply_reset(3, 2'd0);
    for (int i = 0; i < 2 * FT; i++) begin
      cyc(1'b1, 2'd0);
      fs_n += int'(frame_start);
      de_n += int'(vid_de);
      hs_n += int'(vid_hs);
      vs_n += int'(vid_vs);
      n_assert++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL line_timing ce %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_assert++;
    if ({fs_n, de_n, hs_n, vs_n} !== {32'd2, 32'(2 * HA * VA), 32'(2 * HSW * VT), 32'(2 * VSW * HT)}) begin
      n_fail++;
      $display("FAIL line_totals: got fs=%0d de=%0d hs=%0d vs=%0d want 2 %0d %0d %0d",
               fs_n, de_n, hs_n, vs_n, 2 * HA * VA, 2 * HSW * VT, 2 * VSW * HT);
    end
  endtask

  task automatic test_bars();
    apply_reset(3, 2'd1);
    for (int x = 0; x < HT; x++) begin
      cyc(1'b1, 2'd1);
      n_assert++;
      if (vid_rgb !== ((x < HA) ? BARS[x / 2] : 24'h0)) begin
        n_fail++;
        $display("FAIL bars_line0 x %0d: got %h want %h", x, vid_rgb,
                 (x < HA) ? BARS[x / 2] : 24'h0);
      end
    end
    while (m_pos != 4 * HT) begin
      cyc(1'b1, 2'd1);
      n_assert++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL bars_frame pos %0d: got %h want %h", m_pos, obs, exp_vec());
      end
    end
  endtask

  task automatic test_pat_change();
    do begin
      cyc(1'b1, 2'd2);
      n_assert++;
      if (obs !== exp_vec() || (e_de && vid_rgb !== BARS[e_x / 2])) begin
        n_fail++;
        $display("FAIL pat_hold pos %0d: got %h want %h", m_pos, obs, exp_vec());
      end
    end while (m_pos != 0);
    cyc(1'b1, 2'd2);
    n_assert++;
    if (vid_rgb !== 24'h000000) begin
      n_fail++;
      $display("FAIL check_px_0_0: got %h want %h", vid_rgb, 24'h000000);
    end
    repeat (8) cyc(1'b1, 2'd2);
    n_assert++;
    if (vid_rgb !== 24'hFFFFFF || pix_x !== 5'd8) begin
      n_fail++;
      $display("FAIL check_px_8_0: got %h x=%0d want FFFFFF x=8", vid_rgb, pix_x);
    end
  endtask

  task automatic test_throttle();
    int fs_n;
    fs_n = 0;
    apply_reset(3, 2'd0);
    for (int i = 0; i < 3 * FT; i++) begin
      cyc(logic'(i % 3 == 0), 2'd0);
      fs_n += int'(frame_start && (i % 3 == 0));
      n_assert++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL throttle cyc %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_assert++;
    if (fs_n !== 1) begin
      n_fail++;
      $display("FAIL throttle_fs_count: got %0d want 1", fs_n);
    end
  endtask

  task automatic test_random();
    logic [1:0] ps;
    ps = 2'($urandom_range(0, 3));
    apply_reset(2, ps);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) ps = 2'($urandom_range(0, 3));
      cyc(logic'($urandom_range(0, 3) != 0), ps);
      n_assert++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(2, 2'd3);
    while (m_pos != 5 * HT + 10) cyc(1'b1, 2'd3);
    reset_n = 1'b0;
    model_reset();
    #1;
    n_assert++;
    if (obs !== 37'h0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h want %h", obs, 37'h0);
    end
    repeat (2) begin
      @(posedge clk_vid);
      #1;
    end
    n_assert++;
    if (obs !== 37'h0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got %h want %h", obs, 37'h0);
    end
    reset_n = 1'b1;
    cyc(1'b1, 2'd3);
    n_assert++;
    if ({frame_start, vid_de, pix_x, pix_y} !== {1'b1, 1'b1, 5'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got fs=%b de=%b x=%0d y=%0d want 1 1 0 0",
               frame_start, vid_de, pix_x, pix_y);
    end
    repeat (2 * HT) begin
      cyc(1'b1, 2'd3);
      n_assert++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_reset_run pos %0d: got %h want %h", m_pos, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_bars();
    test_pat_change();
    test_throttle();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
